// File: rtl/mm_wr_alloc.sv
// Match-memory write allocator. It takes a four-phase write request, claims the
// lowest free entry, writes it through a one-hot array strobe and acknowledges it.
// Entries are released individually through a one-hot free strobe.
module mm_wr_alloc #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [3:0]    wr_idx,
  output logic [15:0]   mmc_we,
  output logic [DW-1:0] mmc_wdata,
  input  logic          free_req,
  input  logic [15:0]   free_sel,
  output logic [15:0]   entry_vld,
  output logic          full,
  output logic          err_free
);

  typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  alloc_idx;
  logic        free_onehot;
  logic        free_legal;
  logic [15:0] free_mask;
  logic [15:0] set_mask;
  logic [15:0] entry_vld_d;

  assign full = &entry_vld;

  // Lowest-numbered free entry, taken from the registered occupancy bitmap.
  always_comb begin
    alloc_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!entry_vld[i]) alloc_idx = 4'(i);
    end
  end

  // Release decode. Freeing an entry that is not yet valid is an error, which
  // also covers a free racing the WRITE set of the same entry: the set wins.
  always_comb begin
    free_onehot = (free_sel != 16'd0) && ((free_sel & (free_sel - 16'd1)) == 16'd0);
    free_legal  = free_onehot && ((free_sel & entry_vld) != 16'd0);
    free_mask   = (free_req && free_legal) ? free_sel : 16'd0;
    set_mask    = (state_q == StWrite) ? mmc_we : 16'd0;
    entry_vld_d = (entry_vld & ~free_mask) | set_mask;
  end

  // Occupancy bitmap and illegal-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_vld <= 16'h0000;
      err_free  <= 1'b0;
    end else begin
      entry_vld <= entry_vld_d;
      err_free  <= free_req && !free_legal;
    end
  end

  // Request FSM with registered array strobe, write data and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      mmc_we    <= 16'h0000;
      mmc_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_idx    <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_req && !full) begin
            state_q   <= StWrite;
            idx_q     <= alloc_idx;
            mmc_we    <= 16'd1 << alloc_idx;
            mmc_wdata <= wr_data;
          end
        end
        StWrite: begin
          state_q <= StAck;
          mmc_we  <= 16'h0000;
          wr_ack  <= 1'b1;
          wr_idx  <= idx_q;
        end
        StAck: begin
          if (!wr_req) begin
            state_q <= StIdle;
            wr_ack  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          mmc_we  <= 16'h0000;
          wr_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_wr_alloc.sv
// Directed bench for mm_wr_alloc: expected (index, data) pairs are queued when a
// request is driven and popped when the array write strobe appears.
module tb_mm_wr_alloc;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [3:0]    wr_idx;
  logic [15:0]   mmc_we;
  logic [DW-1:0] mmc_wdata;
  logic          free_req;
  logic [15:0]   free_sel;
  logic [15:0]   entry_vld;
  logic          full;
  logic          err_free;

  typedef struct {
    logic [3:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  mm_wr_alloc #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_idx    (wr_idx),
    .mmc_we    (mmc_we),
    .mmc_wdata (mmc_wdata),
    .free_req  (free_req),
    .free_sel  (free_sel),
    .entry_vld (entry_vld),
    .full      (full),
    .err_free  (err_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Array strobe must be one-hot or zero in every cycle.
  always @(negedge clk) begin
    if (rst_n) check("we_onehot0", 32'($onehot0(mmc_we)), 32'd1);
  end

  task automatic check_reset_state();
    check("rst_vld", 32'(entry_vld), 32'h0);
    check("rst_we", 32'(mmc_we), 32'h0);
    check("rst_ack", 32'(wr_ack), 32'h0);
    check("rst_idx", 32'(wr_idx), 32'h0);
    check("rst_wdata", mmc_wdata, 32'h0);
    check("rst_err", 32'(err_free), 32'h0);
    check("rst_full", 32'(full), 32'h0);
  endtask

  // Called at a negedge: raise the request and queue the expected write.
  task automatic write_req(input logic [DW-1:0] d, input logic [3:0] idx);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb_q.push_back(e);
    wr_req  = 1'b1;
    wr_data = d;
  endtask

  // Wait (bounded) for the array strobe, then compare against the scoreboard.
  task automatic wait_we(input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mmc_we == 16'h0 && n < 20);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("we", 32'(mmc_we), 32'(16'd1 << e.idx));
      check("wdata", mmc_wdata, e.data);
      if (exp_lat > 0) check("we_latency", 32'(n), 32'(exp_lat));
    end
    // Data changes after acceptance must not reach the array.
    wr_data = ~wr_data;
  endtask

  // From the WRITE-cycle negedge: check the ack, drop the request, check release.
  task automatic ack_finish(input logic [3:0] idx);
    @(negedge clk);
    check("ack_hi", 32'(wr_ack), 32'h1);
    check("ack_idx", 32'(wr_idx), 32'(idx));
    wr_req = 1'b0;
    @(negedge clk);
    check("ack_lo", 32'(wr_ack), 32'h0);
  endtask

  // Single-cycle free strobe, checked on the following negedge.
  task automatic do_free(input logic [15:0] sel, input logic exp_err, input logic [15:0] exp_vld);
    free_req = 1'b1;
    free_sel = sel;
    @(negedge clk);
    free_req = 1'b0;
    free_sel = 16'h0;
    check("free_err", 32'(err_free), 32'(exp_err));
    check("free_vld", 32'(entry_vld), 32'(exp_vld));
    @(negedge clk);
    check("free_err_lo", 32'(err_free), 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_req   = 1'b0;
    wr_data  = '0;
    free_req = 1'b0;
    free_sel = 16'h0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // First write after reset lands in entry 0.
    write_req(32'hDEADBEEF, 4'd0);
    wait_we(1);
    ack_finish(4'd0);
    check("vld_first", 32'(entry_vld), 32'h0001);

    // Fill the remaining 15 entries in index order.
    for (int i = 1; i < 16; i++) begin
      write_req($urandom, 4'(i));
      wait_we(1);
      ack_finish(4'(i));
    end
    check("vld_full", 32'(entry_vld), 32'h0000FFFF);
    check("full_hi", 32'(full), 32'h1);

    // A 17th request stalls while full, then takes entry 5 once freed.
    write_req(32'hA5A5_0005, 4'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_we", 32'(mmc_we), 32'h0);
      check("stall_ack", 32'(wr_ack), 32'h0);
    end
    free_req = 1'b1;
    free_sel = 16'h0020;
    @(negedge clk);
    free_req = 1'b0;
    free_sel = 16'h0;
    check("free5_vld", 32'(entry_vld), 32'h0000FFDF);
    check("free5_err", 32'(err_free), 32'h0);
    check("free5_we", 32'(mmc_we), 32'h0);
    wait_we(1);
    ack_finish(4'd5);
    check("refill_vld", 32'(entry_vld), 32'h0000FFFF);

    // Illegal releases: multi-bit, zero, and an entry that is already free.
    do_free(16'h0011, 1'b1, 16'hFFFF);
    do_free(16'h0000, 1'b1, 16'hFFFF);
    do_free(16'h0080, 1'b0, 16'hFF7F);
    do_free(16'h0080, 1'b1, 16'hFF7F);

    // Reset in the WRITE cycle of entry 3 aborts the write.
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_req($urandom, 4'(i));
      wait_we(1);
      ack_finish(4'(i));
    end
    write_req(32'h3333_3333, 4'd3);
    wait_we(1);
    rst_n = 1'b0;
    #1;
    check("abort_vld", 32'(entry_vld), 32'h0);
    check("abort_ack", 32'(wr_ack), 32'h0);
    check("abort_we", 32'(mmc_we), 32'h0);
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_vld", 32'(entry_vld), 32'h0);
    check("post_abort_ack", 32'(wr_ack), 32'h0);
    write_req(32'h1234_5678, 4'd0);
    wait_we(1);
    ack_finish(4'd0);
    check("post_abort_vld1", 32'(entry_vld), 32'h0001);

    // Free racing the WRITE of the same entry: set wins, err_free pulses.
    write_req(32'hCAFE_F00D, 4'd1);
    wait_we(1);
    free_req = 1'b1;
    free_sel = 16'h0002;
    @(negedge clk);
    free_req = 1'b0;
    free_sel = 16'h0;
    check("race_vld", 32'(entry_vld), 32'h0003);
    check("race_err", 32'(err_free), 32'h1);
    check("race_ack", 32'(wr_ack), 32'h1);
    check("race_idx", 32'(wr_idx), 32'h1);
    wr_req = 1'b0;
    @(negedge clk);
    check("race_ack_lo", 32'(wr_ack), 32'h0);
    check("race_err_lo", 32'(err_free), 32'h0);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mm_wr_alloc.md
MM_WR_ALLOC -- requirements
Module: mm_wr_alloc

Interface
REQ-001 SHALL have parameter: DW, default 32, width of the entry data word.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: wr_req  input  1  write request, level, four-phase with wr_ack.
REQ-005 SHALL have port: wr_data  input  DW  data to store; sampled when the request is accepted.
REQ-006 SHALL have port: wr_ack  output  1  write complete; held high until wr_req falls.
REQ-007 SHALL have port: wr_idx  output  4  index of the entry written; valid while wr_ack=1.
REQ-008 SHALL have port: mmc_we  output  16  one-hot entry write enable to the match-memory array; bit i writes entry i.
REQ-009 SHALL have port: mmc_wdata  output  DW  write data to the array; valid while mmc_we is nonzero.
REQ-010 SHALL have port: free_req  input  1  single-cycle entry release strobe.
REQ-011 SHALL have port: free_sel  input  16  one-hot entry to release; same encoding as the array match-result vector.
REQ-012 SHALL have port: entry_vld  output  16  registered occupancy bitmap; bit i=1 means entry i holds data.
REQ-013 SHALL have port: full  output  1  combinational AND-reduce of entry_vld.
REQ-014 SHALL have port: err_free  output  1  one-cycle pulse flagging an illegal release.

Function
REQ-015 SHALL implement an FSM with states IDLE, WRITE, ACK.
REQ-016 In IDLE with wr_req=1 and full=0, SHALL latch wr_data and the lowest-numbered index i where entry_vld[i]=0, then go to WRITE.
REQ-017 In IDLE with wr_req=1 and full=1, SHALL remain in IDLE, with no write, until full=0.
REQ-018 In WRITE, SHALL drive mmc_we with exactly bit i set for one cycle and mmc_wdata with the latched data, set entry_vld[i] at the end of the cycle, and go to ACK.
REQ-019 In ACK, SHALL drive wr_ack=1 and wr_idx=i, and stay there until wr_req=0.
REQ-020 When wr_req=0 in ACK, SHALL return to IDLE with wr_ack=0 on the next cycle.
REQ-021 Timing SHALL be: request accepted at edge N, mmc_we high during cycle N+1, wr_ack high from cycle N+2; minimum IDLE-to-IDLE round trip is 4 cycles.
REQ-022 mmc_we SHALL be all-zero outside WRITE and SHALL never have more than one bit set.
REQ-023 free_req=1 with one-hot free_sel selecting a valid entry SHALL clear that entry_vld bit at the next edge, in any FSM state.
REQ-024 free_req=1 with free_sel not one-hot (zero or multi-bit) SHALL leave entry_vld unchanged and pulse err_free on the next cycle.
REQ-025 free_req=1 selecting an entry whose entry_vld bit is 0 SHALL leave entry_vld unchanged and pulse err_free on the next cycle.
REQ-026 A free and the WRITE set of the same entry in the same cycle SHALL be handled as follows: the set wins, entry_vld[i]=1, and err_free pulses, because the entry was invalid when freed.
REQ-027 Allocation SHALL use the registered entry_vld; an entry freed in cycle N is allocatable from cycle N+1.
REQ-028 A wr_req drop before acceptance SHALL cancel the request with no side effects.
REQ-029 wr_data changes after acceptance SHALL have no effect on the stored word.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force: FSM=IDLE, entry_vld=16'h0000, mmc_we=16'h0000, wr_ack=0, wr_idx=0, mmc_wdata=0, err_free=0, full=0.
REQ-031 Reset asserted mid-WRITE or mid-ACK SHALL abort the operation immediately; after release, the entry is not marked valid and no ack is given.
REQ-032 Reset release SHALL be followed by normal operation from the first rising edge with rst_n=1.

Verification
REQ-033 Bench SHALL cover: after reset, wr_req with wr_data=32'hDEADBEEF -> mmc_we=16'h0001 and mmc_wdata=32'hDEADBEEF in cycle N+1; wr_ack=1 and wr_idx=0 from N+2; entry_vld=16'h0001.
REQ-034 Bench SHALL cover: 16 back-to-back writes -> wr_idx 0..15 in order, entry_vld=16'hFFFF, full=1; a 17th wr_req gets no mmc_we and no ack while full.
REQ-035 Bench SHALL cover: full array with 17th request pending, free_req with free_sel=16'h0020 -> entry_vld=16'hFFDF next cycle, then write to index 5 with wr_ack and wr_idx=5.
REQ-036 Bench SHALL cover: free_sel=16'h0011, then free_sel=16'h0000, then freeing an unused entry -> err_free pulses once per case and entry_vld is unchanged.
REQ-037 Bench SHALL cover: rst_n low during the WRITE cycle of index 3 -> entry_vld=0 and wr_ack=0 immediately; the next request writes index 0.
REQ-038 Bench SHALL cover: free of the entry being allocated in the same cycle as WRITE -> entry_vld bit set and err_free=1; assertion checked every cycle that mmc_we is one-hot or zero.
